// File: rtl/branch_target_predictor_if.sv
`default_nettype none
// ============================================================================
// Module      : branch_target_predictor_if
// Description : Fetch-lookup, EX-resolution and statistics signals shared
//               between the pipeline (master) and the branch target
//               predictor (slave).
//   Fetch side : pc_if -> pred_taken, pred_target
//   EX side    : ex_valid, ex_is_branch, ex_pc, ex_br, ex_br_target,
//                ex_pred_taken, ex_pred_target -> ex_mispredict,
//                ex_redirect_pc
//   Statistics : branch_cnt, mispredict_cnt
// Revision    : 1.0 - initial release
// ============================================================================
interface branch_target_predictor_if;
    logic [31:0] pc_if;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid;
    logic        ex_is_branch;
    logic [31:0] ex_pc;
    logic        ex_br;
    logic [31:0] ex_br_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        ex_mispredict;
    logic [31:0] ex_redirect_pc;
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;

    modport master (
        output pc_if, ex_valid, ex_is_branch, ex_pc, ex_br, ex_br_target,
               ex_pred_taken, ex_pred_target,
        input  pred_taken, pred_target, ex_mispredict, ex_redirect_pc,
               branch_cnt, mispredict_cnt
    );

    modport slave (
        input  pc_if, ex_valid, ex_is_branch, ex_pc, ex_br, ex_br_target,
               ex_pred_taken, ex_pred_target,
        output pred_taken, pred_target, ex_mispredict, ex_redirect_pc,
               branch_cnt, mispredict_cnt
    );
endinterface
`default_nettype wire

// File: rtl/branch_target_predictor.sv
`default_nettype none
// ============================================================================
// Module      : branch_target_predictor
// Description : Direct-mapped BTB with 2-bit saturating counters. Gives a
//               zero-latency prediction to fetch, trains on EX resolution,
//               flags mispredicts with a redirect PC and keeps statistics.
// Ports       : clk      - clock, all state updates on posedge
//               rst      - synchronous active-high reset
//               bus_io   - predictor interface (slave modport)
// Revision    : 1.0 - initial release
// ============================================================================
module branch_target_predictor #(
    parameter int unsigned INDEX_BITS = 6
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    branch_target_predictor_if.slave  bus_io
);

    localparam int unsigned c_ENTRIES  = 1 << INDEX_BITS;
    localparam int unsigned c_TAG_BITS = 30 - INDEX_BITS;

    // ------------------------------------------------------------------
    // Storage. Only valid is reset; tag/target/cnt are qualified by it.
    // ------------------------------------------------------------------
    logic [c_ENTRIES-1:0]  valid_q;
    logic [c_TAG_BITS-1:0] tag_q    [c_ENTRIES];
    logic [31:0]           target_q [c_ENTRIES];
    logic [1:0]            cnt_q    [c_ENTRIES];

    logic [31:0] branch_cnt_q;
    logic [31:0] mispredict_cnt_q;

    // ------------------------------------------------------------------
    // Fetch lookup
    // ------------------------------------------------------------------
    logic [INDEX_BITS-1:0] w_if_idx;
    logic [c_TAG_BITS-1:0] w_if_tag;
    logic                  w_if_hit;
    logic                  w_if_taken;

    assign w_if_idx   = bus_io.pc_if[INDEX_BITS+1:2];
    assign w_if_tag   = bus_io.pc_if[31:INDEX_BITS+2];
    assign w_if_hit   = valid_q[w_if_idx] && (tag_q[w_if_idx] == w_if_tag);
    assign w_if_taken = w_if_hit && cnt_q[w_if_idx][1];

    assign bus_io.pred_taken  = w_if_taken;
    assign bus_io.pred_target = w_if_taken ? target_q[w_if_idx]
                                           : bus_io.pc_if + 32'd4;

    // ------------------------------------------------------------------
    // EX resolution
    // ------------------------------------------------------------------
    logic [INDEX_BITS-1:0] w_ex_idx;
    logic [c_TAG_BITS-1:0] w_ex_tag;
    logic                  w_ex_hit;
    logic                  w_mispredict;
    logic                  w_br_valid;

    assign w_ex_idx   = bus_io.ex_pc[INDEX_BITS+1:2];
    assign w_ex_tag   = bus_io.ex_pc[31:INDEX_BITS+2];
    assign w_ex_hit   = valid_q[w_ex_idx] && (tag_q[w_ex_idx] == w_ex_tag);
    assign w_br_valid = bus_io.ex_valid && bus_io.ex_is_branch;

    always_comb begin
        w_mispredict = 1'b0;
        if (bus_io.ex_valid) begin
            if (bus_io.ex_is_branch) begin
                // Direction wrong, or direction right but target wrong.
                w_mispredict = (bus_io.ex_br != bus_io.ex_pred_taken) ||
                               (bus_io.ex_br &&
                                (bus_io.ex_pred_target != bus_io.ex_br_target));
            end else begin
                // A non-branch should never have been predicted taken.
                w_mispredict = bus_io.ex_pred_taken;
            end
        end
    end

    assign bus_io.ex_mispredict  = w_mispredict;
    assign bus_io.ex_redirect_pc = (bus_io.ex_is_branch && bus_io.ex_br)
                                   ? bus_io.ex_br_target
                                   : bus_io.ex_pc + 32'd4;

    // ------------------------------------------------------------------
    // Training decisions
    // ------------------------------------------------------------------
    logic       w_train;
    logic       w_alloc;
    logic       w_invalidate;
    logic [1:0] w_cnt_cur;
    logic [1:0] w_cnt_d;

    assign w_train      = w_br_valid && w_ex_hit;
    assign w_alloc      = w_br_valid && !w_ex_hit && bus_io.ex_br;
    assign w_invalidate = bus_io.ex_valid && !bus_io.ex_is_branch &&
                          bus_io.ex_pred_taken && w_ex_hit;
    assign w_cnt_cur    = cnt_q[w_ex_idx];

    always_comb begin
        w_cnt_d = w_cnt_cur;
        if (bus_io.ex_br) begin
            if (w_cnt_cur != 2'b11) begin
                w_cnt_d = w_cnt_cur + 2'd1;
            end
        end else begin
            if (w_cnt_cur != 2'b00) begin
                w_cnt_d = w_cnt_cur - 2'd1;
            end
        end
    end

    // Valid bits: cleared in one cycle on reset; reset blocks any write.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (w_alloc) begin
            valid_q[w_ex_idx] <= 1'b1;
        end else if (w_invalidate) begin
            valid_q[w_ex_idx] <= 1'b0;
        end
    end

    // Entry payload: not reset, but a coincident reset suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_train) begin
                cnt_q[w_ex_idx] <= w_cnt_d;
                if (bus_io.ex_br) begin
                    target_q[w_ex_idx] <= bus_io.ex_br_target;
                end
            end else if (w_alloc) begin
                tag_q[w_ex_idx]    <= w_ex_tag;
                target_q[w_ex_idx] <= bus_io.ex_br_target;
                cnt_q[w_ex_idx]    <= 2'b10;
            end
        end
    end

    // ------------------------------------------------------------------
    // Statistics (free-running, wrap at 2**32)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            if (w_br_valid) begin
                branch_cnt_q <= branch_cnt_q + 32'd1;
            end
            if (w_mispredict) begin
                mispredict_cnt_q <= mispredict_cnt_q + 32'd1;
            end
        end
    end

    assign bus_io.branch_cnt     = branch_cnt_q;
    assign bus_io.mispredict_cnt = mispredict_cnt_q;

    // Word-offset bits of the PCs carry no information here.
    logic w_unused_bits;
    assign w_unused_bits = ^{bus_io.pc_if[1:0], bus_io.ex_pc[1:0]};

endmodule
`default_nettype wire
